// File: rtl/game_countdown_timer_pkg.sv
// ============================================================================
// Module : game_countdown_timer_pkg
// Brief  : Shared state encoding and BCD constants for the countdown timer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package game_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_NINE = 4'd9;

    localparam int WARN_BLINK_TICKS = 5;

endpackage

`default_nettype wire

// File: rtl/game_countdown_timer_bcd_down_digit.sv
// ============================================================================
// Module : bcd_down_digit
// Brief  : One BCD down-counting digit with load and borrow-out for chaining.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_down_digit
    import game_countdown_timer_pkg::*;
#(
    parameter logic [3:0] RESET_VALUE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec_en,
    output logic [3:0] digit,
    output logic       borrow_out
);

    assign borrow_out = dec_en && (digit == BCD_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= RESET_VALUE;
        end else if (load) begin
            digit <= load_value;
        end else if (dec_en) begin
            digit <= (digit == BCD_ZERO) ? BCD_NINE : digit - 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_countdown_timer.sv
// ============================================================================
// Module : game_countdown_timer
// Brief  : SS.t BCD countdown driven by a 100 ms tick, with expiry pulse.
//          Optional low-time blink output enabled by COUNTDOWN_WARN_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module game_countdown_timer
    import game_countdown_timer_pkg::*;
#(
    parameter int START_TENS = 6,
    parameter int START_ONES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       hundredMsTimeout,
    output logic       timer_enable,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] tenths,
    output logic       running,
    output logic       expired,
    output logic       warn
);

    if (START_TENS < 0 || START_TENS > 9 || START_ONES < 0 || START_ONES > 9) begin : g_param_check
        $error("game_countdown_timer: START_TENS/START_ONES must be 0..9");
    end

    localparam logic [3:0] START_TENS_BCD = 4'(START_TENS);
    localparam logic [3:0] START_ONES_BCD = 4'(START_ONES);

    state_t state;
    state_t next_state;

    logic tick_apply;
    logic tenths_borrow;
    logic ones_borrow;
    logic tens_borrow;
    logic at_one_tenth;
    logic count_zero;

    // Pause and load both mask a coincident tick; only RUN consumes ticks.
    assign tick_apply   = (state == ST_RUN) && hundredMsTimeout && !load && !pause;
    assign at_one_tenth = (sec_tens == BCD_ZERO) && (sec_ones == BCD_ZERO) && (tenths == 4'd1);
    assign count_zero   = (sec_tens == BCD_ZERO) && (sec_ones == BCD_ZERO) && (tenths == BCD_ZERO);

    bcd_down_digit #(.RESET_VALUE(BCD_ZERO)) u_tenths (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (BCD_ZERO),
        .dec_en     (tick_apply),
        .digit      (tenths),
        .borrow_out (tenths_borrow)
    );

    bcd_down_digit #(.RESET_VALUE(START_ONES_BCD)) u_ones (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (START_ONES_BCD),
        .dec_en     (tenths_borrow),
        .digit      (sec_ones),
        .borrow_out (ones_borrow)
    );

    bcd_down_digit #(.RESET_VALUE(START_TENS_BCD)) u_tens (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (START_TENS_BCD),
        .dec_en     (ones_borrow),
        .digit      (sec_tens),
        .borrow_out (tens_borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // tens_borrow can only fire on a tick at 00.0, which the FSM prevents;
    // it is folded into the expiry condition as a backstop.
    always_comb begin
        next_state = state;
        if (load) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !count_zero) begin
                        next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        next_state = ST_PAUSE;
                    end else if (tick_apply && (at_one_tenth || tens_borrow)) begin
                        next_state = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        next_state = ST_RUN;
                    end
                end
                default: begin
                    next_state = ST_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_enable <= 1'b0;
            expired      <= 1'b0;
        end else begin
            timer_enable <= (next_state == ST_RUN);
            expired      <= tick_apply && (at_one_tenth || tens_borrow);
        end
    end

    assign running = (state == ST_RUN);

`ifdef COUNTDOWN_WARN_EN
    logic [2:0] blink_cnt;
    logic       blink_off;
    logic       enter_run;

    assign enter_run = (state != ST_RUN) && (next_state == ST_RUN);

    // Blink phase counts only ticks spent below 10 s so the first toggle
    // comes a full period after warn rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= 3'd0;
            blink_off <= 1'b0;
        end else if (load || enter_run) begin
            blink_cnt <= 3'd0;
            blink_off <= 1'b0;
        end else if (tick_apply && (sec_tens == BCD_ZERO)) begin
            if (blink_cnt == 3'(WARN_BLINK_TICKS - 1)) begin
                blink_cnt <= 3'd0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + 3'd1;
            end
        end
    end

    assign warn = (state == ST_DONE) ||
                  ((sec_tens == BCD_ZERO) &&
                   ((state == ST_PAUSE) || ((state == ST_RUN) && !blink_off)));
`else
    assign warn = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_game_countdown_timer.sv
// ============================================================================
// Module : tb_game_countdown_timer
// Brief  : Directed self-checking bench for game_countdown_timer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_game_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       tick = 1'b0;

    logic       timer_enable;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
    logic       running;
    logic       expired;
    logic       warn;

    logic       z_timer_enable;
    logic [3:0] z_sec_tens;
    logic [3:0] z_sec_ones;
    logic [3:0] z_tenths;
    logic       z_running;
    logic       z_expired;
    logic       z_warn;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef COUNTDOWN_WARN_EN
    localparam logic WARN_ON = 1'b1;
`else
    localparam logic WARN_ON = 1'b0;
`endif

    always #10 clk = ~clk;

    game_countdown_timer #(.START_TENS(6), .START_ONES(0)) dut (
        .clk              (clk),
        .rst              (rst),
        .load             (load),
        .start            (start),
        .pause            (pause),
        .hundredMsTimeout (tick),
        .timer_enable     (timer_enable),
        .sec_tens         (sec_tens),
        .sec_ones         (sec_ones),
        .tenths           (tenths),
        .running          (running),
        .expired          (expired),
        .warn             (warn)
    );

    // Zero-start instance: exercises start being ignored at 00.0.
    game_countdown_timer #(.START_TENS(0), .START_ONES(0)) dut_zero (
        .clk              (clk),
        .rst              (rst),
        .load             (load),
        .start            (start),
        .pause            (pause),
        .hundredMsTimeout (tick),
        .timer_enable     (z_timer_enable),
        .sec_tens         (z_sec_tens),
        .sec_ones         (z_sec_ones),
        .tenths           (z_tenths),
        .running          (z_running),
        .expired          (z_expired),
        .warn             (z_warn)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of pulses, then settle 1 ns after the edge.
    task automatic cyc(input logic l, input logic s, input logic p, input logic t);
        load  = l;
        start = s;
        pause = p;
        tick  = t;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    function automatic logic [11:0] digits();
        return {sec_tens, sec_ones, tenths};
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits", digits(), 12'h600);
        chk("rst_running", {11'd0, running}, 12'd0);
        chk("rst_ten", {11'd0, timer_enable}, 12'd0);
        chk("rst_expired", {11'd0, expired}, 12'd0);
        chk("rst_warn", {11'd0, warn}, 12'd0);
        rst = 1'b0;

        // Load, start, 10 ticks
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("load_digits", digits(), 12'h600);
        chk("load_running", {11'd0, running}, 12'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("start_running", {11'd0, running}, 12'd1);
        chk("start_ten", {11'd0, timer_enable}, 12'd1);
        chk("start_no_dec", digits(), 12'h600);
        chk("zero_start_ignored", {z_sec_tens, z_sec_ones, z_tenths, 3'd0, z_running}, 16'h0000);
        chk("zero_start_ten", {11'd0, z_timer_enable}, 12'd0);
        ticks(10);
        chk("ten_ticks", digits(), 12'h590);
        chk("ten_ticks_ten", {11'd0, timer_enable}, 12'd1);

        // Count to 10.0, then borrow chain into 09.9 and warn blink
        ticks(490);
        chk("at_10_0", digits(), 12'h100);
        chk("warn_10_0", {11'd0, warn}, 12'd0);
        ticks(1);
        chk("borrow_09_9", digits(), 12'h099);
        chk("warn_09_9", {11'd0, warn}, {11'd0, WARN_ON});
        ticks(4);
        chk("warn_09_5", {11'd0, warn}, {11'd0, WARN_ON});
        ticks(1);
        chk("dig_09_4", digits(), 12'h094);
        chk("warn_09_4", {11'd0, warn}, 12'd0);
        ticks(5);
        chk("warn_08_9", {11'd0, warn}, {11'd0, WARN_ON});

        // Run to expiry (tick 600 total)
        ticks(88);
        chk("at_00_1", digits(), 12'h001);
        chk("no_early_expired", {11'd0, expired}, 12'd0);
        ticks(1);
        chk("expired_pulse", {11'd0, expired}, 12'd1);
        chk("done_digits", digits(), 12'h000);
        chk("done_running", {11'd0, running}, 12'd0);
        chk("done_ten", {11'd0, timer_enable}, 12'd0);
        chk("done_warn", {11'd0, warn}, {11'd0, WARN_ON});
        ticks(1);
        chk("expired_one_cycle", {11'd0, expired}, 12'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        ticks(3);
        chk("done_holds", digits(), 12'h000);
        chk("done_start_ignored", {11'd0, running}, 12'd0);
        chk("done_no_repulse", {11'd0, expired}, 12'd0);
        chk("zero_never_expires", {11'd0, z_expired}, 12'd0);

        // Pause at 12.3
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reload_digits", digits(), 12'h600);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(477);
        chk("at_12_3", digits(), 12'h123);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("pause_masks_tick", digits(), 12'h123);
        chk("pause_running", {11'd0, running}, 12'd0);
        chk("pause_ten", {11'd0, timer_enable}, 12'd0);
        ticks(7);
        chk("pause_holds", digits(), 12'h123);
        chk("pause_ten_hold", {11'd0, timer_enable}, 12'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("resume_no_dec", digits(), 12'h123);
        chk("resume_running", {11'd0, running}, 12'd1);
        ticks(1);
        chk("resume_dec", digits(), 12'h122);

        // start+pause together: pause wins in RUN, start wins in PAUSE
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sp_in_run", {11'd0, running}, 12'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sp_in_pause", {11'd0, running}, 12'd1);

        // load+start+tick at 30.0
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(300);
        chk("at_30_0", digits(), 12'h300);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("load_prio_digits", digits(), 12'h600);
        chk("load_prio_running", {11'd0, running}, 12'd0);
        chk("load_prio_ten", {11'd0, timer_enable}, 12'd0);
        ticks(2);
        chk("idle_ignores_tick", digits(), 12'h600);

        // Asynchronous reset mid-cycle while running
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(6);
        chk("pre_rst", digits(), 12'h594);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_digits", digits(), 12'h600);
        chk("async_rst_running", {11'd0, running}, 12'd0);
        chk("async_rst_ten", {11'd0, timer_enable}, 12'd0);
        chk("async_rst_expired", {11'd0, expired}, 12'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ticks(2);
        chk("post_rst_idle", digits(), 12'h600);
        chk("post_rst_no_expired", {11'd0, expired}, 12'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
